// File: rtl/opi_pipe.sv
// Dataflow immediate-operand ALU node with LAT-stage delay pipeline, overflow flag and token counter.
// Optional build macro OPI_SATURATE_EN: ADD/SUB clamp on carry/borrow instead of wrapping.
module opi_pipe #(
  parameter int unsigned     N   = 16,
  parameter longint unsigned I   = 1,
  parameter int unsigned     LAT = 1,
  parameter int unsigned     CW  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          R_IN,
  input  logic [2:0]    OP,
  input  logic [N-1:0]  D_IN,
  output logic          R_OUT,
  output logic [N-1:0]  D_OUT,
  output logic          OVF,
  output logic [CW-1:0] CNT
);

  localparam int unsigned  SW    = $clog2(N);
  localparam logic [N-1:0] IM    = N'(I);
  // N is a power of two, so the low bits are the shift amount mod N.
  localparam logic [SW-1:0] SHAMT = IM[SW-1:0];

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpXor  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpShl  = 3'd5,
    OpShr  = 3'd6,
    OpPass = 3'd7
  } op_e;

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] res;
  logic         res_ovf;

  always_comb begin
    sum     = {1'b0, D_IN} + {1'b0, IM};
    diff    = {1'b0, D_IN} - {1'b0, IM};
    res     = D_IN;
    res_ovf = 1'b0;
    unique case (op_e'(OP))
      OpAnd:  res = D_IN & IM;
      OpOr:   res = D_IN | IM;
      OpXor:  res = D_IN ^ IM;
      OpAdd: begin
        res_ovf = sum[N];
`ifdef OPI_SATURATE_EN
        res     = sum[N] ? {N{1'b1}} : sum[N-1:0];
`else
        res     = sum[N-1:0];
`endif
      end
      OpSub: begin
        res_ovf = diff[N];
`ifdef OPI_SATURATE_EN
        res     = diff[N] ? '0 : diff[N-1:0];
`else
        res     = diff[N-1:0];
`endif
      end
      OpShl:  res = D_IN << SHAMT;
      OpShr:  res = D_IN >> SHAMT;
      OpPass: res = D_IN;
      default: res = D_IN;
    endcase
  end

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] o_q;
  logic [N-1:0]   d_q [LAT];
  logic [CW-1:0]  cnt_q;
  logic           land;

  // A token lands in the last stage on this edge.
  if (LAT == 1) begin : g_land1
    assign land = R_IN;
  end else begin : g_landn
    assign land = v_q[LAT-2];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_q   <= '0;
      o_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        d_q[k] <= '0;
      end
    end else if (EN) begin
      v_q[0] <= R_IN;
      if (R_IN) begin
        d_q[0] <= res;
        o_q[0] <= res_ovf;
      end
      for (int k = 1; k < int'(LAT); k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          d_q[k] <= d_q[k-1];
          o_q[k] <= o_q[k-1];
        end
      end
      if (land) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign R_OUT = v_q[LAT-1];
  assign D_OUT = d_q[LAT-1];
  assign OVF   = o_q[LAT-1];
  assign CNT   = cnt_q;

endmodule

// File: tb/tb_opi_pipe.sv
// Self-checking bench for opi_pipe: two instances (LAT=3/CW=4 and LAT=1/CW=16) share stimulus
// and are checked against a token-history reference model.
module tb_opi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        r_in = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] d_in = '0;

  logic        rout_a, ovf_a, rout_b, ovf_b;
  logic [15:0] dout_a, dout_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  opi_pipe #(.N(16), .I(64'h00FF), .LAT(3), .CW(4)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .R_IN(r_in), .OP(op), .D_IN(d_in),
    .R_OUT(rout_a), .D_OUT(dout_a), .OVF(ovf_a), .CNT(cnt_a)
  );

  opi_pipe #(.N(16), .I(64'h00FF), .LAT(1), .CW(16)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .R_IN(r_in), .OP(op), .D_IN(d_in),
    .R_OUT(rout_b), .D_OUT(dout_b), .OVF(ovf_b), .CNT(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        o;
  } tok_t;

  // Every token accepted on an EN-high edge since the last reset, in order.
  tok_t hist[$];
  int   checks = 0;
  int   errors = 0;

  function automatic tok_t ref_op(logic v, logic [2:0] o, logic [15:0] x);
    tok_t        t;
    int unsigned a  = x;
    int unsigned im = 32'h00FF;
    int unsigned r  = a;
    t.o = 1'b0;
    case (o)
      3'd0: r = a & im;
      3'd1: r = a | im;
      3'd2: r = a ^ im;
      3'd3: begin
        r   = a + im;
        t.o = (r > 32'hFFFF);
`ifdef OPI_SATURATE_EN
        if (t.o) r = 32'hFFFF;
`endif
      end
      3'd4: begin
        t.o = (a < im);
        r   = a - im;
`ifdef OPI_SATURATE_EN
        if (t.o) r = 0;
`endif
      end
      3'd5: r = a << (im % 16);
      3'd6: r = a >> (im % 16);
      default: r = a;
    endcase
    t.v = v;
    t.d = 16'(r);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output state of a LAT=l pipeline after the recorded history.
  task automatic expect_out(input int l, output logic rv, output logic [15:0] d,
                            output logic o, output int c);
    int n = hist.size();
    rv = 1'b0;
    d  = '0;
    o  = 1'b0;
    c  = 0;
    for (int i = 0; i <= n - l; i++) begin
      if (hist[i].v) begin
        d = hist[i].d;
        o = hist[i].o;
        c++;
      end
    end
    if (n >= l) rv = hist[n-l].v;
  endtask

  task automatic check_all();
    logic        rv, o;
    logic [15:0] d;
    int          c;
    expect_out(3, rv, d, o, c);
    check("a_rout", 32'(rout_a), 32'(rv));
    check("a_dout", 32'(dout_a), 32'(d));
    check("a_ovf",  32'(ovf_a),  32'(o));
    check("a_cnt",  32'(cnt_a),  32'(c % 16));
    expect_out(1, rv, d, o, c);
    check("b_rout", 32'(rout_b), 32'(rv));
    check("b_dout", 32'(dout_b), 32'(d));
    check("b_ovf",  32'(ovf_b),  32'(o));
    check("b_cnt",  32'(cnt_b),  32'(c % 65536));
  endtask

  // Called at a falling edge; drives, clocks, checks, returns at the next falling edge.
  task automatic cycle(input logic e, input logic rv, input logic [2:0] o, input logic [15:0] d);
    en   = e;
    r_in = rv;
    op   = o;
    d_in = d;
    @(posedge clk);
    if (e && rst) hist.push_back(ref_op(rv, o, d));
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    hist.delete();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [15:0] sweep_tbl [8] = '{
    16'h0010, 16'hFFFF, 16'hFFEF,
`ifdef OPI_SATURATE_EN
    16'hFFFF,
`else
    16'h000F,
`endif
    16'hFE11, 16'h0000, 16'h0001, 16'hFF10
  };

  initial begin
    @(negedge clk);
    do_reset();

    // Mid-stream reset then single-token latency
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 3'(i), 16'($urandom));
    do_reset();
    cycle(1'b1, 1'b1, 3'd0, 16'h1234);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000);
    check("lat_early", 32'(rout_a), 32'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000);
    check("lat_rout", 32'(rout_a), 32'd1);
    check("lat_dout", 32'(dout_a), 32'h0034);
    check("lat_cnt",  32'(cnt_a),  32'd1);

    // Op sweep, back to back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 3'(i), 16'hFF10);
      check("sweep_dout", 32'(dout_b), 32'(sweep_tbl[i]));
      check("sweep_ovf",  32'(ovf_b),  32'(i == 3));
    end

    // Saturation boundaries
    cycle(1'b1, 1'b1, 3'd3, 16'hFFF0);
`ifdef OPI_SATURATE_EN
    check("add_sat", 32'(dout_b), 32'hFFFF);
`else
    check("add_wrap", 32'(dout_b), 32'h00EF);
`endif
    check("add_ovf", 32'(ovf_b), 32'd1);
    cycle(1'b1, 1'b1, 3'd4, 16'h0001);
`ifdef OPI_SATURATE_EN
    check("sub_sat", 32'(dout_b), 32'h0000);
`else
    check("sub_wrap", 32'(dout_b), 32'hFF02);
`endif
    check("sub_ovf", 32'(ovf_b), 32'd1);

    // Stall mid-stream
    do_reset();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 3'd3, 16'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'($urandom), 3'($urandom), 16'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3'd0, 16'h0000);
    check("stall_cnt_a", 32'(cnt_a), 32'd5);
    check("stall_cnt_b", 32'(cnt_b), 32'd5);

    // Bubbles
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'(~i[0]), 3'($urandom), 16'($urandom));

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom));
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 3'd0, 16'h0000);
    check("wrap_cnt_a", 32'(cnt_a), 32'd1);
    check("wrap_cnt_b", 32'(cnt_b), 32'd17);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else cycle(1'($urandom_range(3) != 0), 1'($urandom), 3'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opi_pipe.md
Name: opi_pipe

Overview:
- Parametrised successor to the single-op immediate operator: one dataflow node applies a runtime-selected ALU operation between the input token and a compile-time immediate.
- Sits between dataflow FIFOs/operators. Uses the same R_IN/R_OUT token-valid convention and global EN freeze.
- Adds configurable pipeline depth, an overflow flag and an emitted-token counter.

Parameters:
- N, 16, data width in bits; power of two, ≥ 4.
- I, 1, immediate operand, truncated to N bits.
- LAT, 1, pipeline depth in EN-cycles from input to output; 1..8.
- CW, 16, width of the token counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  global enable; low freezes the whole pipeline.
- R_IN  input  1  input token valid.
- OP  input  3  operation select, sampled with the token.
- D_IN  input  N  input data.
- R_OUT  output  1  output token valid.
- D_OUT  output  N  result data.
- OVF  output  1  carry/borrow of the result, travels with the token.
- CNT  output  CW  count of tokens emitted on R_OUT.

Behaviour:
- Reset (RST=0, asynchronous): all stage valid bits, data, OVF and CNT are cleared to 0. R_OUT=0, D_OUT=0, OVF=0, CNT=0.
  - Reset mid-operation discards all in-flight tokens.
  - Release is synchronous to the next CLK edge.
- Operation set, Im = I[N-1:0]:
  - 0 AND: D_IN & Im
  - 1 OR: D_IN | Im
  - 2 XOR: D_IN ^ Im
  - 3 ADD: D_IN + Im unsigned; OVF = carry out
  - 4 SUB: D_IN − Im unsigned; OVF = borrow (D_IN < Im)
  - 5 SHL: D_IN << (Im mod N)
  - 6 SHR: logical D_IN >> (Im mod N)
  - 7 PASS: D_IN
  - OVF = 0 for all ops except ADD and SUB.
- Pipeline structure: stages 0..LAT-1, each holding a valid bit, N-bit data and OVF.
  - Result is computed combinationally from D_IN/OP and registered into stage 0.
  - Later stages are pure delay.
- EN=1, per rising edge:
  - v[0] <= R_IN; d[0]/ovf[0] load the new result only when R_IN=1, otherwise they hold.
  - For k ≥ 1: v[k] <= v[k-1]; d[k]/ovf[k] load from stage k-1 only when v[k-1]=1, otherwise they hold.
- EN=0: every register holds, including CNT. Tokens are not lost or duplicated.
- Outputs:
  - R_OUT = v[LAT-1]; D_OUT = d[LAT-1]; OVF = ovf[LAT-1].
  - D_OUT keeps the last valid value while R_OUT=0.
- Latency: a token presented at EN-edge t appears on R_OUT after LAT EN-high edges.
  - Throughput: one token per EN-high cycle; there is no backpressure.
  - Bubbles (R_IN=0) propagate as bubbles.
- CNT increments by 1 on each EN-high edge where v[LAT-1] is being set to 1 (a token lands in the last stage). It wraps from 2^CW−1 to 0.
- OP is sampled only together with R_IN=1. An OP change between tokens does not affect tokens already in flight.

Optional Feature:
- Macro: OPI_SATURATE_EN.
- Defined:
  - ADD clamps the result to all-ones on carry.
  - SUB clamps the result to 0 on borrow.
  - OVF still flags the clamp event.
- Undefined: ADD and SUB wrap modulo 2^N, and OVF reports carry/borrow.
- All other ops are unaffected either way.

Test Plan:
- Reset and latency (N=16, I=0x00FF, LAT=3): hold RST=0 mid-stream → R_OUT, D_OUT, OVF, CNT all 0 immediately. After release, R_IN=1, OP=0, D_IN=0x1234 at edge 0 → R_OUT=1, D_OUT=0x0034 after edge 2, CNT=1.
- Op sweep (I=0x00FF, LAT=1), back-to-back tokens with D_IN=0xFF10 and OP=0..7 → expected D_OUT:
  - 0x0010, 0xFFFF, 0xFFEF, 0x000F (OVF=1), 0xFE11
  - SHL 15 → 0x0000; SHR 15 → 0x0001
  - 0xFF10
- Saturation: D_IN=0xFFF0, OP=3 → without OPI_SATURATE_EN, D_OUT=0x00EF, OVF=1; with it, D_OUT=0xFFFF, OVF=1. Likewise D_IN=0x0001, OP=4 → 0xFF02 or 0x0000, OVF=1.
- Stall (LAT=3): stream 5 tokens, drop EN for 4 cycles mid-stream → no change on outputs or CNT while EN=0. All 5 results emerge in order, CNT=5.
- Bubbles and hold: alternate R_IN 1/0 → R_OUT alternates after LAT; D_OUT holds the prior result during bubbles.
- Counter wrap (CW=4): 17 tokens → CNT=1.
